// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor with start/done handshake and result chaining.
// Optional signed-overflow flag output Ovf when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             St,
  input  logic             Mode,
  input  logic             Chain,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Zero,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             Ovf,
`endif
  output logic             state_dbg
);

  // Handshake: a start is taken when St is high while idle (Busy low); Done pulses
  // for exactly one cycle when Result/Cout/Zero become valid, and St may be raised
  // in that same cycle to begin the next operation with no idle gap.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc, opb, acc_shift;
  logic [CNT_W-1:0]   cnt;
  logic               cb, mode_q;
  logic               x, y, c, s, co, last, start;

  // Serial cell and shift-path values for the current bit
  always_comb begin
    x = acc[0];
    y = opb[0];
    c = cb;
    s = x ^ y ^ c;
    if (mode_q) co = (~x & c) | (y & c) | (~x & y);
    else        co = (x & y) | (x & c) | (y & c);
    acc_shift = {s, acc[WIDTH-1:1]};
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge CLK) begin
    if (R) state <= IDLE;
    else   state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (St) state_next = SHIFT;
      SHIFT:   if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state == SHIFT);
    start     = (state == IDLE) && St;
    state_dbg = state;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      cb     <= 1'b0;
      mode_q <= 1'b0;
      Result <= '0;
      Cout   <= 1'b0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      if (start) begin
        // Chain reuses the last completed result as the first operand
        acc    <= Chain ? Result : A;
        opb    <= B;
        cb     <= 1'b0;
        cnt    <= '0;
        mode_q <= Mode;
      end else if (state == SHIFT) begin
        acc <= acc_shift;
        opb <= {opb[0], opb[WIDTH-1:1]};
        cb  <= co;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          Result <= acc_shift;
          Cout   <= co;
          Zero   <= (acc_shift == '0);
          Done   <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry into MSB xor carry out of MSB = signed overflow
          Ovf    <= cb ^ co;
`endif
        end
      end
    end
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised bit-serial adder/subtractor that succeeds the fixed 8-bit serial subtractor datapath.
- Contains the operand shift register, the rotating second-operand register, the carry/borrow flip-flop and the 1-bit full add/subtract cell, plus a control FSM that was previously missing.
- Operates on WIDTH bits with a start/done handshake and a run-time add/subtract mode.
- Can chain from the previous result, so sequences such as A−B−C run without reloading.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); serial operation takes WIDTH cycles.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- St  input  1  start request; sampled only while idle.
- Mode  input  1  0 = add (A+B), 1 = subtract (A−B); latched at start.
- Chain  input  1  1 = use current Result as first operand instead of A; latched at start.
- A  input  WIDTH  first operand (minuend/augend).
- B  input  WIDTH  second operand (subtrahend/addend).
- Busy  output  1  high while the serial operation is in progress.
- Done  output  1  one-cycle pulse; Result/Cout/Zero valid from this cycle on.
- Result  output  WIDTH  registered result, held until next completion or reset.
- Cout  output  1  final carry (add) or borrow (sub) out of MSB.
- Zero  output  1  registered (Result == 0).

Behaviour:
- State machine: IDLE and SHIFT. Busy = (state == SHIFT).
- Start (edge S):
  - Accepted when state == IDLE, St = 1 and R = 0.
  - acc ← (Chain ? Result : A); opb ← B; cb ← 0; cnt ← 0.
  - Mode and Chain are latched; state → SHIFT.
- Each edge in SHIFT:
  - x = acc[0], y = opb[0], c = cb.
  - Add: s = x^y^c; co = xy | xc | yc.
  - Sub: s = x^y^c; co = ~x&c | y&c | ~x&y.
  - acc ← {s, acc[WIDTH-1:1]} (LSB first, result enters at MSB).
  - opb ← {opb[0], opb[WIDTH-1:1]} (rotate right).
  - cb ← co; cnt ← cnt+1.
- Final shift (edge S+WIDTH, cnt == WIDTH-1):
  - Result ← shifted acc value; Cout ← co; Zero ← (shifted acc == 0).
  - Done ← 1; state → IDLE.
- Latency: Busy high for cycles S+1..S+WIDTH. Done high exactly one cycle after edge S+WIDTH.
- Done clears on the next edge unconditionally.
- St high in the Done cycle is accepted (back-to-back); throughput is one operation per WIDTH+1 cycles.
- Inputs are ignored while SHIFT is active: St, Mode, Chain, A and B changes have no effect on the running operation.
- Arithmetic is modulo 2^WIDTH.
  - Sub with A<B (unsigned) gives Cout = 1.
  - Add overflow beyond WIDTH bits gives Cout = 1.
- Chain with no prior operation uses Result's reset value 0.
- Reset (R = 1 at an edge, overrides everything, including mid-operation):
  - state ← IDLE; acc, opb, cnt, cb ← 0.
  - Result ← 0; Cout ← 0; Zero ← 1; Done ← 0.
  - An aborted operation never produces Done; Busy is low from the next cycle.
- R and St high on the same edge: reset wins, St is ignored.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - Extra output port Ovf (1 bit), registered.
  - Reset value 0.
  - At the final-shift edge, Ovf ← cb ^ co, i.e. carry/borrow into the MSB XOR carry/borrow out = two's-complement signed overflow for the latched Mode.
  - Held until next completion.
- Undefined: no Ovf port and no extra logic; all other behaviour is identical.

Test Plan:
1. WIDTH=8, Mode=1, A=0x2D, B=0xD0, St pulse → Busy 8 cycles, Done one cycle later, Result=0x5D, Cout=1, Zero=0.
2. WIDTH=16, Mode=0, A=0xFFFF, B=0x0001 → after 16 shift cycles Result=0x0000, Cout=1, Zero=1, single Done pulse.
3. Chain: Mode=0, A=0x10, B=0x20 → Result=0x30. Then St in the Done cycle with Chain=1, Mode=1, A=0xAA (ignored), B=0x30 → Result=0x00, Cout=0, Zero=1; second start accepted with no idle gap.
4. Start A=0x05, B=0x03, Mode=0; during Busy toggle St, Mode=1, A=0xFF, B=0xFF → Result=0x08, Cout=0, exactly one Done.
5. Start Mode=1, A=0x2D, B=0xD0; assert R at the 4th shift edge → Busy low next cycle, Result=0x00, Zero=1, Cout=0, no Done pulse; a fresh start afterwards gives the correct result.
6. With SERIAL_ADDSUB_OVF_EN, WIDTH=8:
   - Add 0x7F+0x01 → Result=0x80, Ovf=1, Cout=0.
   - Sub 0x80−0x01 → Result=0x7F, Ovf=1, Cout=0.
   - Add 0x05+0x03 → Ovf=0.
